char_gfx_fetcher: RTL and testbench
===================================

Name: char_gfx_fetcher

Overview:
Graphics-side reader of the 32-bit character RAM.
- Issues one word address per 4-pixel slot, alternating tilemap A and tilemap B.
- Captures the returned 32-bit row word (8 pixels x 4bpp).
- Serialises each layer's row into one 4-bit pixel per pixel clock, with horizontal flip.
- Sits between the tilemap/scroll logic, which supplies codes and line numbers, and the priority/palette mixer.

Parameters:
ADDR_TIMING, 5'b01_000, i_EMU_TIMING value at which o_GFXADDR is loaded.
CAPTURE_TIMING, 5'b11_001, i_EMU_TIMING value at which i_GFXDATA is captured.

Ports:
i_EMU_MCLK  in  1  master clock, 36.864 MHz
i_EMU_MRST_n  in  1  reset, asynchronous, active-low
i_EMU_TIMING  in  5  [4:3] pixel slot 0-3, [2:0] MCLK phase 0-5 within pixel; phases 6-7 never occur
i_GRP  in  1  group half: 0 = TM-A fetch slot (pixels 0-3), 1 = TM-B fetch slot (pixels 4-7)
i_TMA_CODE  in  11  tilemap A character code
i_TMA_VLINE  in  3  tilemap A fine vertical line
i_TMA_HFLIP  in  1  tilemap A horizontal flip
i_TMB_CODE  in  11  tilemap B character code
i_TMB_VLINE  in  3  tilemap B fine vertical line
i_TMB_HFLIP  in  1  tilemap B horizontal flip
o_GFXADDR  out  14  character RAM word address
i_GFXDATA  in  32  character RAM word, big-endian nibble order
o_TMA_PX  out  4  tilemap A pixel
o_TMB_PX  out  4  tilemap B pixel

Behaviour:
- Reset (async): o_GFXADDR, o_TMA_PX, o_TMB_PX = 0. Capture latches, shifters, pending/active flip bits and the pixel index are all cleared to 0.
- Address load, on the edge sampling i_EMU_TIMING==ADDR_TIMING:
  - o_GFXADDR <= {CODE, VLINE} of the layer selected by i_GRP.
  - That layer's HFLIP is stored as its pending flip.
  - o_GFXADDR is held until the next load, so it is stable across the RAM's read window (slot 2, phases 3-5).
- Capture, on the edge sampling CAPTURE_TIMING:
  - i_GFXDATA goes to LATCH_A if i_GRP=0, otherwise LATCH_B.
  - The other latch holds its value.
- Reload, on the edge sampling i_EMU_TIMING==5'b00_000 with i_GRP=0:
  - SHIFT_A <= LATCH_A, SHIFT_B <= LATCH_B.
  - Active flips <= pending flips.
  - Pixel index <= 0.
- Every other edge sampling phase 0 increments the 3-bit pixel index, wrapping 7->0.
- Output, on the edge sampling phase 1: o_TMx_PX <= nibble n of SHIFTx, where n = pixel index.
  - Flip=0: bits [31-4n -: 4].
  - Flip=1: bits [4n+3 -: 4].
- Each pixel is therefore visible from phase 2 of its slot until phase 1 of the next.
- Latency: a code sampled in group g is displayed during group g+1 (8 pixels later).
  - Both layers reload together, so TM-B data fetched in slots 4-7 shows in the immediately following group.
- i_GRP and the tile inputs are sampled only at the timings above; changes at other times have no effect.
- Reset asserted mid-group: outputs drop to 0 immediately. Output is 0 for up to 16 pixels until a full A+B fetch cycle completes.

Optional Feature:
CHARFETCH_VFLIP_EN
- Defined: adds ports i_TMA_VFLIP and i_TMB_VFLIP (1 bit each). The address becomes {CODE, VLINE ^ {3{VFLIP}}}.
- Undefined: the ports are absent and the address is {CODE, VLINE}.

Decomposition:
- Shared package: pixel-slot and phase constants, default ADDR_TIMING/CAPTURE_TIMING values, nibble-width and address-width constants.
- One sub-module, char_row_serialiser, instantiated twice:
  - Holds a 32-bit shifter and active flip bit.
  - Takes reload/index inputs and produces a registered 4-bit pixel.

Test Plan:
- Reset then idle timing -> o_GFXADDR=0, o_TMA_PX=o_TMB_PX=0 throughout.
- GRP=0, TMA_CODE=11'h155, VLINE=3 at timing 01_000 -> o_GFXADDR=14'h0AAB, held through slot 2 phase 5.
- GFXDATA=32'h01234567 captured for A, HFLIP=0 -> next group o_TMA_PX sequence 0,1,2,3,4,5,6,7, each changing at phase 1.
- Same data, HFLIP=1 -> sequence 7,6,5,4,3,2,1,0; TM-B with 32'hFEDCBA98, HFLIP=0 concurrently outputs F,E,D,C,B,A,9,8.
- Reset pulse at slot 2 of group -> outputs 0 at once; first non-zero pixels appear one full group after the next A and B fetches complete.
- CHARFETCH_VFLIP_EN defined, TMB_CODE=0, VLINE=1, VFLIP=1 -> o_GFXADDR=14'h0006.

Source files
------------

// File: rtl/char_gfx_fetcher_pkg.sv
// Shared widths, timing constants and the row-word nibble selector for the
// character graphics fetcher.
package char_gfx_fetcher_pkg;

    localparam int TIMING_W = 5;
    localparam int PHASE_W  = 3;
    localparam int CODE_W   = 11;
    localparam int VLINE_W  = 3;
    localparam int ADDR_W   = CODE_W + VLINE_W;
    localparam int WORD_W   = 32;
    localparam int NIBBLE_W = 4;
    localparam int IDX_W    = 3;

    // {pixel slot[1:0], MCLK phase[2:0]}
    localparam logic [TIMING_W-1:0] ADDR_TIMING_DEF    = 5'b01_000;
    localparam logic [TIMING_W-1:0] CAPTURE_TIMING_DEF = 5'b11_001;
    localparam logic [TIMING_W-1:0] RELOAD_TIMING      = 5'b00_000;

    localparam logic [PHASE_W-1:0] PHASE_ADVANCE = 3'd0;
    localparam logic [PHASE_W-1:0] PHASE_OUTPUT  = 3'd1;

    // Pixel 0 is the most-significant nibble; a flipped row reads from the LS end.
    function automatic logic [NIBBLE_W-1:0] row_nibble(
        input logic [WORD_W-1:0] row,
        input logic [IDX_W-1:0]  idx,
        input logic              flip
    );
        logic [IDX_W-1:0] pos;
        pos = flip ? idx : ~idx;
        return row[{pos, 2'b11} -: NIBBLE_W];
    endfunction

endpackage

// File: rtl/char_gfx_fetcher_if.sv
// Timing, tile, character-RAM and pixel signals of the fetcher.
// CHARFETCH_VFLIP_EN adds the per-layer vertical flip inputs.
interface char_gfx_fetcher_if;
    import char_gfx_fetcher_pkg::*;

    logic [TIMING_W-1:0] i_EMU_TIMING;
    logic                i_GRP;
    logic [CODE_W-1:0]   i_TMA_CODE;
    logic [VLINE_W-1:0]  i_TMA_VLINE;
    logic                i_TMA_HFLIP;
    logic [CODE_W-1:0]   i_TMB_CODE;
    logic [VLINE_W-1:0]  i_TMB_VLINE;
    logic                i_TMB_HFLIP;
`ifdef CHARFETCH_VFLIP_EN
    logic                i_TMA_VFLIP;
    logic                i_TMB_VFLIP;
`endif
    logic [ADDR_W-1:0]   o_GFXADDR;
    logic [WORD_W-1:0]   i_GFXDATA;
    logic [NIBBLE_W-1:0] o_TMA_PX;
    logic [NIBBLE_W-1:0] o_TMB_PX;

    modport master (
        output i_EMU_TIMING, i_GRP,
               i_TMA_CODE, i_TMA_VLINE, i_TMA_HFLIP,
               i_TMB_CODE, i_TMB_VLINE, i_TMB_HFLIP,
               i_GFXDATA,
        input  o_GFXADDR, o_TMA_PX, o_TMB_PX
`ifdef CHARFETCH_VFLIP_EN
        , output i_TMA_VFLIP, i_TMB_VFLIP
`endif
    );

    modport slave (
        input  i_EMU_TIMING, i_GRP,
               i_TMA_CODE, i_TMA_VLINE, i_TMA_HFLIP,
               i_TMB_CODE, i_TMB_VLINE, i_TMB_HFLIP,
               i_GFXDATA,
        output o_GFXADDR, o_TMA_PX, o_TMB_PX
`ifdef CHARFETCH_VFLIP_EN
        , input i_TMA_VFLIP, i_TMB_VFLIP
`endif
    );

endinterface

// File: rtl/char_gfx_fetcher_row_serialiser.sv
// One layer's row shifter: holds the 8-pixel row word and its flip, and
// emits a registered 4-bit pixel selected by the shared pixel index.
module char_row_serialiser
    import char_gfx_fetcher_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                reload_i,
    input  logic [WORD_W-1:0]   row_i,
    input  logic                flip_i,
    input  logic                out_en_i,
    input  logic [IDX_W-1:0]    idx_i,
    output logic [NIBBLE_W-1:0] px_o
);

    logic [WORD_W-1:0]   shift_q, shift_d;
    logic                flip_q,  flip_d;
    logic [NIBBLE_W-1:0] px_q,    px_d;

    always_comb begin
        // NOTE: every next-state value is defaulted to its hold value first, so
        // no path through this block can leave one unassigned and infer a latch.
        shift_d = shift_q;
        flip_d  = flip_q;
        px_d    = px_q;
        if (reload_i) begin
            shift_d = row_i;
            flip_d  = flip_i;
        end
        if (out_en_i) begin
            px_d = row_nibble(shift_q, idx_i, flip_q);
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            flip_q  <= 1'b0;
            px_q    <= '0;
        end else begin
            shift_q <= shift_d;
            flip_q  <= flip_d;
            px_q    <= px_d;
        end
    end

    assign px_o = px_q;

endmodule

// File: rtl/char_gfx_fetcher.sv
// Character RAM reader: alternates TM-A / TM-B row fetches and serialises both
// layers one pixel per slot. CHARFETCH_VFLIP_EN enables vertical-flip addressing.
module char_gfx_fetcher
    import char_gfx_fetcher_pkg::*;
#(
    parameter logic [TIMING_W-1:0] ADDR_TIMING    = ADDR_TIMING_DEF,
    parameter logic [TIMING_W-1:0] CAPTURE_TIMING = CAPTURE_TIMING_DEF
) (
    input  logic             i_EMU_MCLK,
    input  logic             i_EMU_MRST_n,
    char_gfx_fetcher_if.slave gfx
);

    logic at_addr, at_capture, at_reload, at_advance, at_output;

    assign at_addr    = (gfx.i_EMU_TIMING == ADDR_TIMING);
    assign at_capture = (gfx.i_EMU_TIMING == CAPTURE_TIMING);
    assign at_reload  = (gfx.i_EMU_TIMING == RELOAD_TIMING) && !gfx.i_GRP;
    assign at_advance = (gfx.i_EMU_TIMING[PHASE_W-1:0] == PHASE_ADVANCE);
    assign at_output  = (gfx.i_EMU_TIMING[PHASE_W-1:0] == PHASE_OUTPUT);

    logic [VLINE_W-1:0] vline_a, vline_b;
`ifdef CHARFETCH_VFLIP_EN
    assign vline_a = gfx.i_TMA_VLINE ^ {VLINE_W{gfx.i_TMA_VFLIP}};
    assign vline_b = gfx.i_TMB_VLINE ^ {VLINE_W{gfx.i_TMB_VFLIP}};
`else
    assign vline_a = gfx.i_TMA_VLINE;
    assign vline_b = gfx.i_TMB_VLINE;
`endif

    logic [ADDR_W-1:0] addr_q,        addr_d;
    logic [WORD_W-1:0] latch_a_q,     latch_a_d;
    logic [WORD_W-1:0] latch_b_q,     latch_b_d;
    logic              pend_flip_a_q, pend_flip_a_d;
    logic              pend_flip_b_q, pend_flip_b_d;
    logic [IDX_W-1:0]  pix_idx_q,     pix_idx_d;

    always_comb begin
        addr_d        = addr_q;
        latch_a_d     = latch_a_q;
        latch_b_d     = latch_b_q;
        pend_flip_a_d = pend_flip_a_q;
        pend_flip_b_d = pend_flip_b_q;
        pix_idx_d     = pix_idx_q;

        if (at_addr) begin
            if (gfx.i_GRP) begin
                addr_d        = {gfx.i_TMB_CODE, vline_b};
                pend_flip_b_d = gfx.i_TMB_HFLIP;
            end else begin
                addr_d        = {gfx.i_TMA_CODE, vline_a};
                pend_flip_a_d = gfx.i_TMA_HFLIP;
            end
        end

        if (at_capture) begin
            if (gfx.i_GRP) latch_b_d = gfx.i_GFXDATA;
            else           latch_a_d = gfx.i_GFXDATA;
        end

        // Index runs 0-3 over the A half and 4-7 over the B half of each cycle.
        if (at_reload)       pix_idx_d = '0;
        else if (at_advance) pix_idx_d = pix_idx_q + 3'd1;
    end

    always_ff @(posedge i_EMU_MCLK or negedge i_EMU_MRST_n) begin
        if (!i_EMU_MRST_n) begin
            addr_q        <= '0;
            latch_a_q     <= '0;
            latch_b_q     <= '0;
            pend_flip_a_q <= 1'b0;
            pend_flip_b_q <= 1'b0;
            pix_idx_q     <= '0;
        end else begin
            addr_q        <= addr_d;
            latch_a_q     <= latch_a_d;
            latch_b_q     <= latch_b_d;
            pend_flip_a_q <= pend_flip_a_d;
            pend_flip_b_q <= pend_flip_b_d;
            pix_idx_q     <= pix_idx_d;
        end
    end

    logic [NIBBLE_W-1:0] px_a, px_b;

    char_row_serialiser u_row_a (
        .clk      (i_EMU_MCLK),
        .rst_n    (i_EMU_MRST_n),
        .reload_i (at_reload),
        .row_i    (latch_a_q),
        .flip_i   (pend_flip_a_q),
        .out_en_i (at_output),
        .idx_i    (pix_idx_q),
        .px_o     (px_a)
    );

    char_row_serialiser u_row_b (
        .clk      (i_EMU_MCLK),
        .rst_n    (i_EMU_MRST_n),
        .reload_i (at_reload),
        .row_i    (latch_b_q),
        .flip_i   (pend_flip_b_q),
        .out_en_i (at_output),
        .idx_i    (pix_idx_q),
        .px_o     (px_b)
    );

    assign gfx.o_GFXADDR = addr_q;
    assign gfx.o_TMA_PX  = px_a;
    assign gfx.o_TMB_PX  = px_b;

endmodule

// File: tb/tb_char_gfx_fetcher.sv
// Scoreboard bench for char_gfx_fetcher: a small character RAM model answers
// o_GFXADDR, and a monitor checks every pixel slot against queued expectations.
module tb_char_gfx_fetcher;
    import char_gfx_fetcher_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    char_gfx_fetcher_if gfx ();

    char_gfx_fetcher dut (
        .i_EMU_MCLK   (clk),
        .i_EMU_MRST_n (rst_n),
        .gfx          (gfx)
    );

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
    } px_pair_t;

    typedef struct {
        logic [10:0] code;
        logic [2:0]  vline;
        logic        hflip;
        logic        vflip;
    } tile_t;

    px_pair_t sb_q[$];
    int       n_checks = 0;
    int       n_errors = 0;
    bit       mon_en   = 1'b0;
    logic [3:0] last_a, last_b;

    logic [31:0] prev_a_row, prev_b_row;
    logic        prev_a_flip, prev_b_flip;

    function automatic logic [31:0] ram_word(input logic [13:0] addr);
        case (addr)
            14'h0AAB: return 32'h01234567;
            14'h1505: return 32'hFEDCBA98;
            14'h0011: return 32'h13579BDF;
            14'h3FFF: return 32'hC0FFEE42;
            default:  return 32'h0;
        endcase
    endfunction

    always_comb gfx.i_GFXDATA = ram_word(gfx.o_GFXADDR);

    function automatic logic [3:0] model_px(input logic [31:0] row, input int n, input logic flip);
        logic [31:0] s;
        s = flip ? (row >> (4 * n)) : (row >> (28 - 4 * n));
        return s[3:0];
    endfunction

    function automatic logic [13:0] exp_addr(input tile_t t);
`ifdef CHARFETCH_VFLIP_EN
        return {t.code, t.vline ^ {3{t.vflip}}};
`else
        return {t.code, t.vline};
`endif
    endfunction

    function automatic tile_t mk_tile(input logic [10:0] code, input logic [2:0] vline,
                                      input logic hflip, input logic vflip);
        tile_t t;
        t.code  = code;
        t.vline = vline;
        t.hflip = hflip;
        t.vflip = vflip;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Tile inputs carry real values only on the address-load step; otherwise junk.
    task automatic set_tiles(input tile_t ta, input tile_t tb, input bit live);
        gfx.i_TMA_CODE  = live ? ta.code  : ~ta.code;
        gfx.i_TMA_VLINE = live ? ta.vline : ~ta.vline;
        gfx.i_TMA_HFLIP = live ? ta.hflip : ~ta.hflip;
        gfx.i_TMB_CODE  = live ? tb.code  : ~tb.code;
        gfx.i_TMB_VLINE = live ? tb.vline : ~tb.vline;
        gfx.i_TMB_HFLIP = live ? tb.hflip : ~tb.hflip;
`ifdef CHARFETCH_VFLIP_EN
        gfx.i_TMA_VFLIP = live ? ta.vflip : ~ta.vflip;
        gfx.i_TMB_VFLIP = live ? tb.vflip : ~tb.vflip;
`endif
    endtask

    // Monitor: each pixel appears at phase 2 and must still be held at phase 1 of the next slot.
    always @(negedge clk) begin
        if (!mon_en) begin
            last_a <= 4'h0;
            last_b <= 4'h0;
        end else if (gfx.i_EMU_TIMING[2:0] == 3'd2) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 32'(sb_q.size()), 32'd1);
            end else begin
                check("px_a", 32'(gfx.o_TMA_PX), 32'(sb_q[0].a));
                check("px_b", 32'(gfx.o_TMB_PX), 32'(sb_q[0].b));
                last_a <= sb_q[0].a;
                last_b <= sb_q[0].b;
                void'(sb_q.pop_front());
            end
        end else if (gfx.i_EMU_TIMING[2:0] == 3'd1) begin
            check("hold_a", 32'(gfx.o_TMA_PX), 32'(last_a));
            check("hold_b", 32'(gfx.o_TMB_PX), 32'(last_b));
        end
    end

    // One 8-pixel cycle: A-half (GRP=0) then B-half (GRP=1), 4 slots x 6 phases each.
    task automatic run_cycle(input tile_t ta, input tile_t tb, input bit do_reset);
        px_pair_t e;
        mon_en = 1'b1;
        for (int n = 0; n < 8; n++) begin
            e.a = model_px(prev_a_row, n, prev_a_flip);
            e.b = model_px(prev_b_row, n, prev_b_flip);
            sb_q.push_back(e);
        end
        for (int g = 0; g < 2; g++) begin
            for (int s = 0; s < 4; s++) begin
                for (int p = 0; p < 6; p++) begin
                    gfx.i_EMU_TIMING = {2'(s), 3'(p)};
                    gfx.i_GRP        = 1'(g);
                    set_tiles(ta, tb, (s == 1 && p == 0));
                    if (do_reset && g == 1 && s == 2 && p == 0) begin
                        #1 rst_n = 1'b0;
                        #1;
                        check("rst_addr", 32'(gfx.o_GFXADDR), 32'd0);
                        check("rst_px_a", 32'(gfx.o_TMA_PX), 32'd0);
                        check("rst_px_b", 32'(gfx.o_TMB_PX), 32'd0);
                        mon_en = 1'b0;
                        sb_q.delete();
                        #1 rst_n = 1'b1;
                    end
                    @(negedge clk);
                    if (s == 2 && (p == 3 || p == 5) && !(do_reset && g == 1))
                        check("gfxaddr", 32'(gfx.o_GFXADDR),
                              32'(exp_addr(g == 1 ? tb : ta)));
                    @(posedge clk);
                    #1;
                end
            end
        end
        if (do_reset) begin
            prev_a_row  = 32'h0;
            prev_b_row  = 32'h0;
            prev_a_flip = 1'b0;
            prev_b_flip = 1'b0;
        end else begin
            prev_a_row  = ram_word(exp_addr(ta));
            prev_b_row  = ram_word(exp_addr(tb));
            prev_a_flip = ta.hflip;
            prev_b_flip = tb.hflip;
        end
    endtask

    initial begin
        tile_t t0;
        t0 = mk_tile(11'h000, 3'd0, 1'b0, 1'b0);
        prev_a_row  = 32'h0;
        prev_b_row  = 32'h0;
        prev_a_flip = 1'b0;
        prev_b_flip = 1'b0;

        rst_n            = 1'b0;
        gfx.i_EMU_TIMING = 5'b00_000;
        gfx.i_GRP        = 1'b0;
        set_tiles(t0, t0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("reset_addr", 32'(gfx.o_GFXADDR), 32'd0);
        check("reset_px_a", 32'(gfx.o_TMA_PX), 32'd0);
        check("reset_px_b", 32'(gfx.o_TMB_PX), 32'd0);
        rst_n = 1'b1;

        // First cycle after reset shows zeros while fetching 0x0AAB / 0x1505.
        run_cycle(mk_tile(11'h155, 3'd3, 1'b0, 1'b0), mk_tile(11'h2A0, 3'd5, 1'b0, 1'b0), 1'b0);
        // A: 0..7 unflipped, B: F..8 (from the previous fetch).
        run_cycle(mk_tile(11'h155, 3'd3, 1'b1, 1'b0), mk_tile(11'h2A0, 3'd5, 1'b0, 1'b0), 1'b0);
        // A: 7..0 flipped, B: F..8.
        run_cycle(mk_tile(11'h002, 3'd1, 1'b0, 1'b0), mk_tile(11'h7FF, 3'd7, 1'b1, 1'b0), 1'b0);
        run_cycle(mk_tile(11'h7FF, 3'd7, 1'b0, 1'b0), mk_tile(11'h002, 3'd1, 1'b1, 1'b0), 1'b0);
        // Reset during slot 2 of the B half: everything drops to 0.
        run_cycle(mk_tile(11'h155, 3'd3, 1'b0, 1'b0), mk_tile(11'h2A0, 3'd5, 1'b0, 1'b0), 1'b1);
        // Zeros for one more cycle while a full A+B fetch completes.
        run_cycle(mk_tile(11'h002, 3'd1, 1'b1, 1'b0), mk_tile(11'h155, 3'd3, 1'b1, 1'b0), 1'b0);
`ifdef CHARFETCH_VFLIP_EN
        run_cycle(mk_tile(11'h2A0, 3'd5, 1'b0, 1'b0), mk_tile(11'h000, 3'd1, 1'b0, 1'b1), 1'b0);
        check("vflip_addr", 32'(exp_addr(mk_tile(11'h000, 3'd1, 1'b0, 1'b1))), 32'h0006);
`else
        run_cycle(mk_tile(11'h2A0, 3'd5, 1'b0, 1'b0), mk_tile(11'h7FF, 3'd7, 1'b0, 1'b0), 1'b0);
`endif
        run_cycle(mk_tile(11'h155, 3'd3, 1'b0, 1'b0), mk_tile(11'h155, 3'd3, 1'b0, 1'b0), 1'b0);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
